// File: rtl/esfa_bank_pkg.sv
// esfa_bank_pkg: shared opcode constants, FSM encoding and response flag
// layout for the ESFA cell bank.
package esfa_bank_pkg;

  localparam logic [2:0] OP_LOOKUP = 3'd0;
  localparam logic [2:0] OP_UPDATE = 3'd1;
  localparam logic [2:0] OP_DELETE = 3'd2;
  localparam logic [2:0] OP_COUNT  = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Single-bit response flags travel together in one packed word.
  typedef struct packed {
    logic ok;
    logic err;
  } resp_flags_t;

endpackage

// File: rtl/esfa_bank_cell.sv
// esfa_bank_cell: one ESFA element (valid, code, index, value) with
// combinational match outputs against the broadcast handle/key.
module esfa_bank_cell
  import esfa_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] handle,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_alloc,
  input  logic              wr_value,
  input  logic              wr_clear,
  output logic              hit,
  output logic              member,
  output logic              free,
  output logic [DATA_W-1:0] value
);

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [DATA_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] value_q, value_d;

  // Next entry contents from the write strobes; clear wins over the rest.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    index_d = index_q;
    value_d = value_q;
    if (wr_alloc) begin
      valid_d = 1'b1;
      code_d  = handle;
      index_d = key;
      value_d = wr_data;
    end else if (wr_value) begin
      value_d = wr_data;
    end
    if (wr_clear) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage; reset empties the cell at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      index_q <= '0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      index_q <= index_d;
      value_q <= value_d;
    end
  end

  assign member = valid_q && (code_q == handle);
  assign hit    = member && (index_q == key);
  assign free   = !valid_q;
  assign value  = value_q;

endmodule

// File: rtl/esfa_cell_bank.sv
// esfa_cell_bank: NCELLS ESFA cells behind one command port. Each command
// is broadcast to every cell, match vectors are reduced by lowest-index
// priority or popcount, and a registered response is returned.
// Optional macro ESFA_BANK_STATS_EN adds the occupancy/full outputs.
module esfa_cell_bank
  import esfa_bank_pkg::*;
#(
  parameter int NCELLS = 8,
  parameter int DATA_W = 8,
  parameter int CODE_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [CODE_W-1:0]            cmd_handle,
  input  logic [DATA_W-1:0]            cmd_index,
  input  logic [DATA_W-1:0]            cmd_value,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_bool,
  output logic [DATA_W-1:0]            resp_value,
  output logic                         resp_err
`ifdef ESFA_BANK_STATS_EN
  ,
  output logic [$clog2(NCELLS+1)-1:0]  occupancy,
  output logic                         full
`endif
);

  localparam int CNT_W = $clog2(NCELLS + 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [CODE_W-1:0] handle_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] wdata_q;
  resp_flags_t       flags_q, flags_d;
  logic [DATA_W-1:0] rvalue_q, rvalue_d;

  logic [NCELLS-1:0] hit_vec, member_vec, free_vec;
  logic [NCELLS-1:0] hit_oh, free_oh;
  logic [NCELLS-1:0] wr_alloc, wr_value, wr_clear;
  logic [DATA_W-1:0] cell_val [NCELLS];
  logic [DATA_W-1:0] hit_val;
  logic [CNT_W-1:0]  mem_cnt;
  logic              hit_any, free_any, exec, accept;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NCELLS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NCELLS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] oh_to_idx(input logic [NCELLS-1:0] oh);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NCELLS; i++) if (oh[i]) r = r | DATA_W'(i);
    return r;
  endfunction

  for (genvar g = 0; g < NCELLS; g++) begin : g_cell
    esfa_bank_cell #(
      .DATA_W(DATA_W),
      .CODE_W(CODE_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .handle  (handle_q),
      .key     (key_q),
      .wr_data (wdata_q),
      .wr_alloc(wr_alloc[g]),
      .wr_value(wr_value[g]),
      .wr_clear(wr_clear[g]),
      .hit     (hit_vec[g]),
      .member  (member_vec[g]),
      .free    (free_vec[g]),
      .value   (cell_val[g])
    );
  end

  assign exec      = (state_q == ST_EXEC);
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && (state_q == ST_IDLE);

  // Isolate the lowest set bit (v & -v) to pick the lowest-numbered cell.
  assign hit_oh   = hit_vec & (~hit_vec + NCELLS'(1));
  assign free_oh  = free_vec & (~free_vec + NCELLS'(1));
  assign hit_any  = |hit_vec;
  assign free_any = |free_vec;
  assign mem_cnt  = popcnt(member_vec);

  // Value of the winning hit cell; zero when nothing hits.
  always_comb begin
    hit_val = '0;
    for (int i = 0; i < NCELLS; i++) if (hit_oh[i]) hit_val = hit_val | cell_val[i];
  end

  // Cell write strobes, only asserted during EXEC so they land at its end.
  always_comb begin
    wr_value = '0;
    wr_alloc = '0;
    wr_clear = '0;
    if (exec) begin
      case (op_q)
        OP_UPDATE: begin
          wr_value = hit_oh;
          wr_alloc = hit_any ? '0 : free_oh;
        end
        OP_DELETE: wr_clear = hit_oh;
        OP_CLEAR:  wr_clear = member_vec;
        default:   ;
      endcase
    end
  end

  // Response word for the registered command.
  always_comb begin
    flags_d  = '0;
    rvalue_d = '0;
    case (op_q)
      OP_LOOKUP: begin
        flags_d.ok = hit_any;
        rvalue_d   = hit_val;
      end
      OP_UPDATE: begin
        if (hit_any) begin
          flags_d.ok = 1'b1;
          rvalue_d   = oh_to_idx(hit_oh);
        end else if (free_any) begin
          flags_d.ok = 1'b1;
          rvalue_d   = oh_to_idx(free_oh);
        end else begin
          flags_d.err = 1'b1;
        end
      end
      OP_DELETE: begin
        flags_d.ok = hit_any;
        rvalue_d   = hit_val;
      end
      OP_COUNT, OP_CLEAR: begin
        flags_d.ok = (mem_cnt != '0);
        rvalue_d   = DATA_W'(mem_cnt);
      end
      default: flags_d.err = 1'b1;
    endcase
  end

  // Sequencing: accept, execute for one cycle, hold response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Command capture at the IDLE handshake; ignored at all other times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_LOOKUP;
      handle_q <= '0;
      key_q    <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      op_q     <= cmd_op;
      handle_q <= cmd_handle;
      key_q    <= cmd_index;
      wdata_q  <= cmd_value;
    end
  end

  // Response registers load at the end of EXEC and hold through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      rvalue_q <= '0;
    end else if (exec) begin
      flags_q  <= flags_d;
      rvalue_q <= rvalue_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_bool  = flags_q.ok;
  assign resp_err   = flags_q.err;
  assign resp_value = rvalue_q;

`ifdef ESFA_BANK_STATS_EN
  logic [CNT_W-1:0] occ_q, occ_d;

  assign occ_d = popcnt((~free_vec | wr_alloc) & ~wr_clear);

  // Occupancy tracks the cell valid bits as they will be after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == CNT_W'(NCELLS));
`endif

endmodule

// File: tb/tb_esfa_cell_bank.sv
// tb_esfa_cell_bank: directed plus randomized commands against an
// array-based reference model of the cell bank.
module tb_esfa_cell_bank;
  import esfa_bank_pkg::*;

  localparam int NC = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [CW-1:0] cmd_handle = '0;
  logic [DW-1:0] cmd_index = '0;
  logic [DW-1:0] cmd_value = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_bool;
  logic [DW-1:0] resp_value;
  logic          resp_err;
`ifdef ESFA_BANK_STATS_EN
  logic [$clog2(NC+1)-1:0] occupancy;
  logic                    full;
`endif

  int vectors = 0;
  int miscompares = 0;

  bit            mv   [NC];
  logic [CW-1:0] mc   [NC];
  logic [DW-1:0] mi   [NC];
  logic [DW-1:0] mval [NC];

  esfa_cell_bank #(.NCELLS(NC), .DATA_W(DW), .CODE_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_handle(cmd_handle), .cmd_index(cmd_index), .cmd_value(cmd_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bool(resp_bool),
    .resp_value(resp_value), .resp_err(resp_err)
`ifdef ESFA_BANK_STATS_EN
    , .occupancy(occupancy), .full(full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < NC; i++) if (mv[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mv[i] = 1'b0; mc[i] = '0; mi[i] = '0; mval[i] = '0;
    end
  endtask

  // Reference behaviour of one command applied to the element table.
  task automatic model_cmd(input logic [2:0] op, input logic [CW-1:0] h,
                           input logic [DW-1:0] k, input logic [DW-1:0] v,
                           output logic eb, output logic [DW-1:0] ev, output logic ee);
    int hit = -1;
    int fr = -1;
    int cnt = 0;
    for (int i = 0; i < NC; i++) begin
      if (mv[i] && mc[i] == h) begin
        cnt++;
        if (mi[i] == k && hit < 0) hit = i;
      end
      if (!mv[i] && fr < 0) fr = i;
    end
    eb = 1'b0; ev = '0; ee = 1'b0;
    case (op)
      3'd0: if (hit >= 0) begin eb = 1'b1; ev = mval[hit]; end
      3'd1: begin
        if (hit >= 0) begin
          mval[hit] = v; eb = 1'b1; ev = DW'(hit);
        end else if (fr >= 0) begin
          mv[fr] = 1'b1; mc[fr] = h; mi[fr] = k; mval[fr] = v;
          eb = 1'b1; ev = DW'(fr);
        end else begin
          ee = 1'b1;
        end
      end
      3'd2: if (hit >= 0) begin eb = 1'b1; ev = mval[hit]; mv[hit] = 1'b0; end
      3'd3: begin ev = DW'(cnt); eb = (cnt != 0); end
      3'd4: begin
        ev = DW'(cnt); eb = (cnt != 0);
        for (int i = 0; i < NC; i++) if (mv[i] && mc[i] == h) mv[i] = 1'b0;
      end
      default: ee = 1'b1;
    endcase
  endtask

  // One full command: handshake, latency, response, optional back-pressure.
  task automatic issue(input logic [2:0] op, input logic [CW-1:0] h,
                       input logic [DW-1:0] k, input logic [DW-1:0] v, input int hold);
    logic eb, ee;
    logic [DW-1:0] ev;
    int n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    model_cmd(op, h, k, v, eb, ev, ee);
    cmd_valid = 1'b1; cmd_op = op; cmd_handle = h; cmd_index = k; cmd_value = v;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_handle = CW'($urandom);
    cmd_index = DW'($urandom); cmd_value = DW'($urandom);
    chk("exec_resp_valid", resp_valid, 0);
    chk("exec_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_bool", resp_bool, eb);
    chk("resp_value", resp_value, ev);
    chk("resp_err", resp_err, ee);
    for (int c = 0; c < hold; c++) begin
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_bool", resp_bool, eb);
      chk("hold_value", resp_value, ev);
      chk("hold_err", resp_err, ee);
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_hs_resp_valid", resp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
`ifdef ESFA_BANK_STATS_EN
    chk("occupancy", occupancy, model_occ());
    chk("full", full, model_occ() == NC);
`endif
  endtask

  initial begin
    int r;
    model_reset();

    // Reset state
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_bool", resp_bool, 0);
    chk("rst_resp_value", resp_value, 0);
    chk("rst_resp_err", resp_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
`ifdef ESFA_BANK_STATS_EN
    chk("rst_occupancy", occupancy, 0);
`endif

    // Empty lookup, insert, overwrite
    issue(OP_LOOKUP, 8'd1, 8'd5, 8'h00, 0);
    issue(OP_UPDATE, 8'd1, 8'd5, 8'hAA, 0);
    issue(OP_LOOKUP, 8'd1, 8'd5, 8'h00, 0);
    chk("lookup_aa_const", resp_value, 8'hAA);
    issue(OP_UPDATE, 8'd1, 8'd5, 8'h55, 0);
    issue(OP_LOOKUP, 8'd1, 8'd5, 8'h00, 0);
    chk("lookup_55_const", resp_value, 8'h55);

    // Fill the bank, overflow, delete cell 3, retry
    for (int j = 0; j < 7; j++) issue(OP_UPDATE, 8'd1, DW'(10 + j), DW'($urandom), 0);
    issue(OP_UPDATE, 8'd1, 8'd20, 8'h99, 0);
    chk("full_update_err", resp_err, 1);
    issue(OP_DELETE, 8'd1, 8'd12, 8'h00, 0);
    issue(OP_UPDATE, 8'd1, 8'd20, 8'h99, 0);
    chk("retry_cell3", resp_value, 3);
    issue(OP_CLEAR, 8'd1, 8'd0, 8'h00, 0);
    chk("clear_all_8", resp_value, 8);

    // Per-array count and clear
    for (int j = 0; j < 3; j++) issue(OP_UPDATE, 8'd2, DW'(j), DW'($urandom), 0);
    for (int j = 0; j < 2; j++) issue(OP_UPDATE, 8'd3, DW'(j), DW'($urandom), 0);
    issue(OP_COUNT, 8'd2, 8'd0, 8'h00, 0);
    chk("count2_const", resp_value, 3);
    issue(OP_CLEAR, 8'd2, 8'd0, 8'h00, 0);
    issue(OP_COUNT, 8'd2, 8'd0, 8'h00, 0);
    issue(OP_COUNT, 8'd3, 8'd0, 8'h00, 0);
    chk("count3_const", resp_value, 2);

    // Back-pressure and reserved opcode
    issue(OP_LOOKUP, 8'd3, 8'd1, 8'h00, 4);
    issue(3'd6, 8'd3, 8'd1, 8'h42, 0);
    issue(3'd6, 8'd3, 8'd7, 8'h42, 1);
    issue(OP_COUNT, 8'd3, 8'd0, 8'h00, 0);

    // Randomized traffic over a small key space
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      issue((r < 3) ? OP_UPDATE : (r < 5) ? OP_LOOKUP : (r < 7) ? OP_DELETE :
            (r == 7) ? OP_COUNT : (r == 8) ? OP_CLEAR : 3'($urandom_range(5, 7)),
            CW'($urandom_range(0, 2)), DW'($urandom_range(0, 3)), DW'($urandom),
            $urandom_range(0, 2));
    end

    // Reset during EXEC of an UPDATE
    issue(OP_UPDATE, 8'd7, 8'd1, 8'h11, 0);
    cmd_valid = 1'b1; cmd_op = OP_UPDATE; cmd_handle = 8'd5; cmd_index = 8'd9; cmd_value = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pre_rst_exec", resp_valid, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
`ifdef ESFA_BANK_STATS_EN
    chk("mid_rst_occupancy", occupancy, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", resp_valid, 0);
    end
    issue(OP_LOOKUP, 8'd5, 8'd9, 8'h00, 0);
    chk("rst_no_alloc", resp_bool, 0);
    issue(OP_LOOKUP, 8'd7, 8'd1, 8'h00, 0);
    chk("rst_invalidated", resp_bool, 0);
    issue(OP_COUNT, 8'd7, 8'd0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
